// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
// ==========================================================================
// dmem_mmio_pkg : MMIO offsets, TXSTAT layout, reset constants, decoder
// Rev 1.0
// ==========================================================================
package dmem_mmio_pkg;

  localparam logic [4:0] OFF_TXDATA  = 5'h00;
  localparam logic [4:0] OFF_TXSTAT  = 5'h04;
  localparam logic [4:0] OFF_TIMER   = 5'h08;
  localparam logic [4:0] OFF_TIMECMP = 5'h0C;
  localparam logic [4:0] OFF_IRQCTL  = 5'h10;

  localparam int TXSTAT_FULL    = 0;
  localparam int TXSTAT_EMPTY   = 1;
  localparam int TXSTAT_OVF     = 2;
  localparam int TXSTAT_CNT_LSB = 4;
  localparam int TXSTAT_CNT_W   = 5;

  localparam logic [31:0] TIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_TXSTAT,
    SEL_TIMER,
    SEL_TIMECMP,
    SEL_IRQCTL,
    SEL_NONE
  } mmio_sel_e;

  function automatic mmio_sel_e addr_decode(input logic is_mmio, input logic [4:0] off);
    mmio_sel_e sel;
    sel = SEL_NONE;
    if (!is_mmio) begin
      sel = SEL_RAM;
    end else begin
      case (off)
        OFF_TXDATA:  sel = SEL_TXDATA;
        OFF_TXSTAT:  sel = SEL_TXSTAT;
        OFF_TIMER:   sel = SEL_TIMER;
        OFF_TIMECMP: sel = SEL_TIMECMP;
        OFF_IRQCTL:  sel = SEL_IRQCTL;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_if.sv
`default_nettype none
// ==========================================================================
// dmem_mmio_if : core load/store port plus TX drain and timer interrupt
// Rev 1.0
// ==========================================================================
interface dmem_mmio_if;
  logic        memWE;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq_timer;

  modport master (
    output memWE, aluout, writedata, tx_ready,
    input  readdata, tx_data, tx_valid, irq_timer
  );

  modport slave (
    input  memWE, aluout, writedata, tx_ready,
    output readdata, tx_data, tx_valid, irq_timer
  );
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_sync_fifo.sv
`default_nettype none
// ==========================================================================
// sync_fifo : single-clock FIFO; a write while full is accepted if a pop happens
// Rev 1.0
// ==========================================================================
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_count
);

  localparam int              c_ptr_w    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               w_push, w_pop;

  always_comb begin
    w_pop    = i_rd_en && (count_q != '0);
    w_push   = i_wr_en && ((count_q != c_full_cnt) || w_pop);
    wr_ptr_d = wr_ptr_q + c_ptr_w'(w_push);
    rd_ptr_d = rd_ptr_q + c_ptr_w'(w_pop);
    count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_full    = (count_q == c_full_cnt);
  assign o_empty   = (count_q == '0);
  assign o_drop    = i_wr_en && !w_push;
  assign o_count   = count_q;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ==========================================================================
// dmem_mmio : data RAM, TX byte FIFO and compare timer behind the load/store port
// Rev 1.0
// ==========================================================================
module dmem_mmio #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  dmem_mmio_if.slave  bus
);
  import dmem_mmio_pkg::*;

  localparam int c_ram_aw = $clog2(RAM_WORDS);
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);

  logic [31:0]         ram_q [RAM_WORDS];
  logic [c_ram_aw-1:0] w_ram_idx;
  mmio_sel_e           w_sel;

  logic [31:0] timer_q, timer_d;
  logic [31:0] timecmp_q, timecmp_d;
  logic        irq_en_q, irq_en_d;
  logic        pending_q, pending_d;
  logic        ovf_q, ovf_d;

  logic               w_tx_wr, w_tx_full, w_tx_empty, w_tx_drop;
  logic [c_cnt_w-1:0] w_tx_count;
  logic [31:0]        w_txstat;
  logic               w_unused;

  assign w_ram_idx = bus.aluout[c_ram_aw+1:2];
  assign w_sel     = addr_decode(bus.aluout[31] == MMIO_BASE[31], bus.aluout[4:0]);
  assign w_tx_wr   = bus.memWE && (w_sel == SEL_TXDATA);
  // Address bits above the RAM index are deliberately ignored.
  assign w_unused  = &{1'b0, bus.aluout};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_wr_en   (w_tx_wr),
    .i_wr_data (bus.writedata[7:0]),
    .i_rd_en   (bus.tx_ready),
    .o_rd_data (bus.tx_data),
    .o_full    (w_tx_full),
    .o_empty   (w_tx_empty),
    .o_drop    (w_tx_drop),
    .o_count   (w_tx_count)
  );

  always_comb begin
    timer_d   = timer_q + 32'd1;
    timecmp_d = timecmp_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (bus.memWE) begin
      case (w_sel)
        SEL_TXSTAT:  ovf_d     = 1'b0;
        SEL_TIMER:   timer_d   = bus.writedata;
        SEL_TIMECMP: timecmp_d = bus.writedata;
        SEL_IRQCTL: begin
          irq_en_d = bus.writedata[0];
          if (bus.writedata[1]) pending_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (w_tx_drop) ovf_d = 1'b1;
    // Applied last so a match beats a same-cycle write-1-clear.
    if (timer_q == timecmp_q) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q   <= '0;
      timecmp_q <= TIMECMP_RST;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timecmp_q <= timecmp_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.memWE && (w_sel == SEL_RAM)) ram_q[w_ram_idx] <= bus.writedata;
  end

  always_comb begin
    w_txstat                                      = '0;
    w_txstat[TXSTAT_FULL]                         = w_tx_full;
    w_txstat[TXSTAT_EMPTY]                        = w_tx_empty;
    w_txstat[TXSTAT_OVF]                          = ovf_q;
    w_txstat[TXSTAT_CNT_LSB +: TXSTAT_CNT_W]      = TXSTAT_CNT_W'(w_tx_count);
    case (w_sel)
      SEL_RAM:     bus.readdata = ram_q[w_ram_idx];
      SEL_TXSTAT:  bus.readdata = w_txstat;
      SEL_TIMER:   bus.readdata = timer_q;
      SEL_TIMECMP: bus.readdata = timecmp_q;
      SEL_IRQCTL:  bus.readdata = {30'b0, pending_q, irq_en_q};
      default:     bus.readdata = '0;
    endcase
  end

  assign bus.tx_valid  = !w_tx_empty;
  assign bus.irq_timer = irq_en_q && pending_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ==========================================================================
// tb_dmem_mmio : directed vector table, corner sequences and random model check
// Rev 1.0
// ==========================================================================
module tb_dmem_mmio;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MM    = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;

  dmem_mmio_if bus();

  dmem_mmio #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (DEPTH),
    .MMIO_BASE  (32'h8000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_irq;
  } vec_t;

  vec_t tv[$];

  // Behavioural reference state
  logic [31:0] m_ram [int];
  logic [7:0]  m_q[$];
  logic [31:0] m_tmr, m_cmp;
  logic        m_en, m_pend, m_ovf;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic rdy, input logic chk_rd, input logic [31:0] exp_rd,
                              input logic exp_valid, input logic [7:0] exp_data, input logic exp_irq);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy; v.chk_rd = chk_rd;
    v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.exp_data = exp_data; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic rdy);
    bus.memWE = we; bus.aluout = addr; bus.writedata = wd; bus.tx_ready = rdy;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.memWE = 1'b0; bus.aluout = '0; bus.writedata = '0; bus.tx_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, output logic known);
    logic [31:0] r;
    int sz;
    known = 1'b1;
    r = '0;
    sz = m_q.size();
    if (!addr[31]) begin
      if (m_ram.exists(int'(addr[11:2]))) r = m_ram[int'(addr[11:2])];
      else known = 1'b0;
    end else begin
      case (addr[4:0])
        5'h04: r = {23'b0, 5'(sz), 1'b0, m_ovf, sz == 0, sz == DEPTH};
        5'h08: r = m_tmr;
        5'h0C: r = m_cmp;
        5'h10: r = {30'b0, m_pend, m_en};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic void model_edge(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                     input logic rdy);
    logic        match;
    logic [31:0] ntmr;
    match = (m_tmr == m_cmp);
    ntmr  = m_tmr + 32'd1;
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (we) begin
      if (!addr[31]) m_ram[int'(addr[11:2])] = wd;
      else begin
        case (addr[4:0])
          5'h00: if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]); else m_ovf = 1'b1;
          5'h04: m_ovf = 1'b0;
          5'h08: ntmr = wd;
          5'h0C: m_cmp = wd;
          5'h10: begin m_en = wd[0]; if (wd[1]) m_pend = 1'b0; end
          default: ;
        endcase
      end
    end
    if (match) m_pend = 1'b1;
    m_tmr = ntmr;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] e;
    logic [31:0] a, w;
    logic        we, rdy, known;

    do_reset();

    // ---- vector table: reset state, RAM wrap, FIFO fill/overflow/drain ----
    tv.push_back(mk(0, MM + 32'h04, 0, 0, 1, 32'h2, 0, 0, 0));
    tv.push_back(mk(0, MM + 32'h10, 0, 0, 1, 32'h0, 0, 0, 0));
    tv.push_back(mk(0, MM + 32'h0C, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0));
    tv.push_back(mk(0, MM + 32'h08, 0, 0, 1, 32'd3, 0, 0, 0));
    tv.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 32'h10, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0));
    tv.push_back(mk(0, 32'h1010, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, MM, 32'h41 + 32'(i), 0, 0, 0, i != 0, 8'h41, 0));
    tv.push_back(mk(0, MM + 32'h04, 0, 0, 1, 32'h81, 1, 8'h41, 0));
    tv.push_back(mk(1, MM, 32'h49, 0, 0, 0, 1, 8'h41, 0));
    tv.push_back(mk(0, MM + 32'h04, 0, 0, 1, 32'h85, 1, 8'h41, 0));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(0, MM + 32'h04, 0, 1, 1, (32'(8 - i) << 4) | 32'h4 | 32'(i == 0),
                      1, 8'h41 + 8'(i), 0));
    tv.push_back(mk(0, MM + 32'h04, 0, 1, 1, 32'h6, 0, 0, 0));
    tv.push_back(mk(1, MM + 32'h04, 32'h1234, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, MM + 32'h04, 0, 0, 1, 32'h2, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].we, tv[i].addr, tv[i].wd, tv[i].rdy);
      if (tv[i].chk_rd) chk($sformatf("vec%0d readdata", i), bus.readdata, tv[i].exp_rd);
      chk($sformatf("vec%0d tx_valid", i), 32'(bus.tx_valid), 32'(tv[i].exp_valid));
      if (tv[i].exp_valid) chk($sformatf("vec%0d tx_data", i), 32'(bus.tx_data), 32'(tv[i].exp_data));
      chk($sformatf("vec%0d irq_timer", i), 32'(bus.irq_timer), 32'(tv[i].exp_irq));
      tick();
    end

    // ---- full FIFO: write with simultaneous pop is accepted ----
    for (int i = 0; i < 8; i++) begin drive(1, MM, 32'h41 + 32'(i), 0); tick(); end
    drive(1, MM, 32'h50, 1);
    chk("fullpop head", 32'(bus.tx_data), 32'h41);
    tick();
    drive(0, MM + 32'h04, 0, 0);
    chk("fullpop txstat", bus.readdata, 32'h81);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 32'h0, 0, 1);
      chk($sformatf("fullpop drain%0d", i), 32'(bus.tx_data), (i < 7) ? 32'h42 + 32'(i) : 32'h50);
      tick();
    end
    drive(0, MM + 32'h04, 0, 0);
    chk("fullpop valid", 32'(bus.tx_valid), 32'h0);
    chk("fullpop empty", bus.readdata, 32'h2);
    tick();

    // ---- timer compare, sticky pending, clear, reload, set-beats-clear ----
    drive(1, MM + 32'h08, 32'd100, 0); tick();
    drive(1, MM + 32'h0C, 32'd105, 0); tick();
    drive(1, MM + 32'h10, 32'd1, 0);   tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, MM + 32'h08, 0, 0);
      chk($sformatf("tmr count%0d", k), bus.readdata, 32'd102 + 32'(k));
      chk($sformatf("tmr irq_low%0d", k), 32'(bus.irq_timer), 32'h0);
      tick();
    end
    drive(0, MM + 32'h10, 0, 0);
    chk("tmr irq_rise", 32'(bus.irq_timer), 32'h1);
    chk("tmr irqctl", bus.readdata, 32'h3);
    tick();
    drive(0, MM + 32'h08, 0, 0);
    chk("tmr sticky val", bus.readdata, 32'd107);
    chk("tmr sticky irq", 32'(bus.irq_timer), 32'h1);
    tick();
    drive(1, MM + 32'h10, 32'd3, 0); chk("tmr pre_clear", 32'(bus.irq_timer), 32'h1); tick();
    drive(0, MM + 32'h10, 0, 0);
    chk("tmr cleared ctl", bus.readdata, 32'h1);
    chk("tmr cleared irq", 32'(bus.irq_timer), 32'h0);
    tick();
    drive(1, MM + 32'h08, 32'd105, 0); tick();
    drive(0, MM + 32'h08, 0, 0);
    chk("tmr reload val", bus.readdata, 32'd105);
    chk("tmr reload irq", 32'(bus.irq_timer), 32'h0);
    tick();
    drive(0, MM + 32'h10, 0, 0);
    chk("tmr reassert ctl", bus.readdata, 32'h3);
    chk("tmr reassert irq", 32'(bus.irq_timer), 32'h1);
    tick();
    drive(1, MM + 32'h10, 32'd3, 0); tick();
    drive(1, MM + 32'h0C, 32'd300, 0); chk("setwin pre", 32'(bus.irq_timer), 32'h0); tick();
    drive(1, MM + 32'h08, 32'd298, 0); tick();
    drive(0, MM + 32'h08, 0, 0); chk("setwin t298", bus.readdata, 32'd298); tick();
    drive(0, MM + 32'h08, 0, 0); chk("setwin t299", bus.readdata, 32'd299); tick();
    drive(1, MM + 32'h10, 32'd3, 0); chk("setwin match_cyc", 32'(bus.irq_timer), 32'h0); tick();
    drive(0, MM + 32'h10, 0, 0);
    chk("setwin ctl", bus.readdata, 32'h3);
    chk("setwin irq", 32'(bus.irq_timer), 32'h1);
    tick();
    drive(1, MM + 32'h10, 32'd0, 0); tick();

    // ---- timer wrap ----
    drive(1, MM + 32'h08, 32'hFFFF_FFFE, 0); tick();
    for (int k = 0; k < 3; k++) begin
      e = 32'hFFFF_FFFE + 32'(k);
      drive(0, MM + 32'h08, 0, 0);
      chk($sformatf("wrap%0d", k), bus.readdata, e);
      tick();
    end

    // ---- asynchronous reset while draining ----
    drive(1, MM + 32'h10, 32'd1, 0); tick();
    for (int i = 0; i < 3; i++) begin drive(1, MM, 32'h61 + 32'(i), 0); tick(); end
    drive(0, 32'h0, 0, 1); chk("rst predrain", 32'(bus.tx_data), 32'h61); tick();
    bus.memWE = 1'b0; bus.aluout = MM + 32'h10; bus.tx_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst irqctl", bus.readdata, 32'h0);
    chk("rst irq", 32'(bus.irq_timer), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, MM + 32'h14, 0, 0);
    chk("rst off14", bus.readdata, 32'h0);
    chk("rst valid_after", 32'(bus.tx_valid), 32'h0);
    tick();

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_ram.delete(); m_q.delete();
    m_tmr = '0; m_cmp = 32'hFFFF_FFFF; m_en = 1'b0; m_pend = 1'b0; m_ovf = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      we  = 1'($urandom_range(0, 1));
      w   = $urandom;
      rdy = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = ($urandom & 32'h7FFF_F000) | (32'($urandom_range(0, 15)) << 2)
                        | 32'($urandom_range(0, 3));
        4:          begin a = MM; we = 1'b1; end
        5:          a = MM + 32'h04;
        6:          a = MM + 32'h08;
        7:          begin a = MM + 32'h0C; w = m_tmr + 32'($urandom_range(1, 6)); end
        8:          a = MM + 32'h10;
        default:    a = MM | 32'($urandom_range(0, 31));
      endcase
      drive(we, a, w, rdy);
      e = model_read(a, known);
      if (known) chk($sformatf("rnd%0d readdata", n), bus.readdata, e);
      chk($sformatf("rnd%0d tx_valid", n), 32'(bus.tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk($sformatf("rnd%0d tx_data", n), 32'(bus.tx_data), 32'(m_q[0]));
      chk($sformatf("rnd%0d irq", n), 32'(bus.irq_timer), 32'(m_en && m_pend));
      model_edge(we, a, w, rdy);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
Data-memory stage on the core's load/store port (memWE, aluout, writedata, readdata).
Decodes each word address into one of three targets:
- word-addressed data RAM;
- byte transmit FIFO with a valid/ready drain port;
- free-running timer with compare interrupt.
Reads are combinational, matching the core's same-cycle readdata expectation. Writes commit on the rising clock edge.

Parameters:
RAM_WORDS, 1024, data RAM depth in 32-bit words; power of two.
FIFO_DEPTH, 8, TX FIFO depth in bytes; power of two, 2..16.
MMIO_BASE, 32'h8000_0000, base address of the MMIO window; only addr[31] is decoded.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
memWE  in  1  store strobe from core
aluout  in  32  byte address from core
writedata  in  32  store data
readdata  out  32  load data, combinational
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head byte this cycle
irq_timer  out  1  timer interrupt, level

Behaviour:
Decode:
- addr[31]=0 selects RAM, word index addr[log2(RAM_WORDS)+1:2]. Higher bits are ignored, so the RAM wraps modulo RAM_WORDS. addr[1:0] is ignored; all accesses are whole words.
- addr[31]=1 selects MMIO, offset addr[4:0]:
  - 0x00 TXDATA: W pushes writedata[7:0]; R returns 0.
  - 0x04 TXSTAT: R returns {23'b0, count[4:0], 1'b0, ovf, empty, full}. W of any value clears ovf.
  - 0x08 TIMER: R returns the counter; W loads writedata.
  - 0x0C TIMECMP: R/W.
  - 0x10 IRQCTL: bit0 enable (R/W), bit1 pending (R; writing 1 clears). Other bits read 0.
  - Other offsets: read 0, write ignored.

Reset (reset=0, asynchronous):
- FIFO pointers and count 0; tx_valid=0.
- ovf=0, TIMER=0, TIMECMP=32'hFFFF_FFFF, enable=0, pending=0, irq_timer=0.
- RAM contents are not reset and are undefined.
- Reset assertion mid-drain discards all queued bytes.

RAM:
- Read is combinational from aluout.
- Write occurs at posedge when memWE=1.
- A load to the same address in the cycle after a store returns the new data.

Timer:
- Counter increments by 1 every cycle and wraps FFFF_FFFF -> 0.
- A TIMER write overrides the increment in that cycle; the next cycle reads exactly writedata.
- pending sets at the edge ending any cycle where counter==TIMECMP, and stays set (sticky).
- If a match and a write-1-clear occur in the same cycle, set wins.
- irq_timer = enable & pending, registered-state derived with no extra latency.

TX FIFO:
- tx_data = mem[rd_ptr]; tx_valid = (count != 0).
- pop = tx_valid & tx_ready.
- push = TXDATA write & (count < FIFO_DEPTH | pop).
- A TXDATA write with count == FIFO_DEPTH and no pop is dropped and sets ovf (sticky).
- Simultaneous push and pop leaves count unchanged and advances both pointers.
- Pointers wrap modulo FIFO_DEPTH.
- full = (count == FIFO_DEPTH); empty = (count == 0).
- Count is registered; status reads reflect state before the current cycle's edge.

Decomposition:
- Package dmem_mmio_pkg:
  - MMIO offset constants: OFF_TXDATA, OFF_TXSTAT, OFF_TIMER, OFF_TIMECMP, OFF_IRQCTL.
  - TXSTAT bit positions.
  - Reset constant TIMECMP_RST.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH):
  - push/pop/full/empty/count, with the push-when-full-with-pop rule above.
  - Reused later for an RX path.
- RAM and timer stay inline.

Test Plan:
- Reset then store 32'hDEAD_BEEF to 0x0000_0010; next cycle load 0x10 -> readdata=DEAD_BEEF. Load 0x0000_1010 with RAM_WORDS=1024 -> same value (wrap).
- Hold tx_ready=0 and write bytes 0x41..0x48 to TXDATA -> TXSTAT count=8, full=1. Write 0x49 -> dropped, ovf=1. Raise tx_ready -> tx_data sequence 41..48, then tx_valid=0 and empty=1.
- With FIFO full and tx_ready=1, write 0x50 in the same cycle -> accepted. Count stays 8. The byte drained after 0x48 is 0x50.
- Write TIMER=100, TIMECMP=105, IRQCTL=1 -> irq_timer rises after the cycle the counter reads 105 and stays high. Write IRQCTL=3 -> irq_timer falls. Reload TIMER=105 -> irq_timer re-asserts.
- Write TIMER=FFFF_FFFE -> reads FFFF_FFFE, FFFF_FFFF, 0000_0000 on consecutive cycles.
- Assert reset mid-drain with 3 bytes queued -> tx_valid=0 immediately and IRQCTL reads 0. After release, load MMIO 0x14 -> 0.
